sync_fifo_ram: RTL and testbench
================================

Name: sync_fifo_ram

Overview:
- Parametrised single-clock FIFO built on an internal dual-port register-file RAM.
- Generalises the fixed 32x8 storage array:
  - configurable WIDTH and DEPTH;
  - separate registered read/write ports instead of a shared tri-state bus;
  - write/read pointers with arbitrary-depth wrap;
  - occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses.
- Sits between producer and consumer logic in the FIFO datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 32, number of storage words (>=2; not required to be a power of two).
- AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- Derived: AW = clog2(DEPTH), CW = clog2(DEPTH+1).

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- wr_en, in, 1, write request.
- wr_data, in, WIDTH, write data, sampled with wr_en.
- rd_en, in, 1, read request.
- rd_data, out, WIDTH, registered read data.
- rd_valid, out, 1, rd_data holds a newly popped word this cycle.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
- almost_full, out, 1, count >= AF_LEVEL.
- almost_empty, out, 1, count <= AE_LEVEL.
- count, out, CW, current occupancy 0..DEPTH.
- overflow, out, 1, one-cycle pulse: write rejected.
- underflow, out, 1, one-cycle pulse: read rejected.

Behaviour:
- Reset (async assert, synchronous release):
  - wr_ptr = rd_ptr = 0, count = 0.
  - rd_data = 0, rd_valid = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored data immediately.
- Acceptance, evaluated on registered state before the edge:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc). When full, a simultaneous accepted read frees a slot, so the write is also accepted.
  - When empty, a read is rejected even if a write occurs the same cycle. There is no fall-through.
- Write: on wr_acc, mem[wr_ptr] <= wr_data. wr_ptr increments and wraps from DEPTH-1 to 0 by explicit compare, not by width overflow.
- Read:
  - On rd_acc, rd_data <= mem[rd_ptr]; rd_valid <= 1. rd_ptr increments and wraps the same way.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is 1 cycle: data is visible in the cycle after the accepting edge.
- Same-address collision (read and write of one slot in one cycle) is only possible when the FIFO is full. Read returns the old word: read-before-write.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged on both or neither.
  - Never leaves 0..DEPTH.
- Flags full, empty, almost_full and almost_empty decode from the registered count. They change in the cycle after the causing edge; no combinational path from wr_en/rd_en.
- overflow <= wr_en & ~wr_acc; underflow <= rd_en & ~rd_acc. Each is a pulse, not sticky.
- No state machine beyond the pointer/count registers. Behaviour is fully defined by the acceptance rules above.

Decomposition:
- Shared package (fifo_pkg):
  - clog2 function;
  - default WIDTH/DEPTH constants;
  - a pointer-increment-with-wrap function taking DEPTH.
- One sub-module: ram_dp_sync.
  - Parameters WIDTH and DEPTH.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata.
  - Registered read, read-before-write.
  - No reset on the array.
- Pointer, count, flag and error logic stays in sync_fifo_ram.

Test Plan (WIDTH=8, DEPTH=32, AF=28, AE=4 unless stated):
- Reset, then idle 3 cycles -> empty=1, full=0, almost_empty=1, count=0, rd_data=0, rd_valid=0, no pulses.
- Write 0x00..0x1F in 32 consecutive cycles, then 1 extra write of 0xAA -> count=32, full=1, almost_full from count=28, overflow pulses once. Then read 32 -> rd_data 0x00..0x1F in order, each 1 cycle after rd_en. 0xAA is never seen.
- Empty FIFO, rd_en=1 and wr_en=1 with 0x55 in the same cycle -> underflow=1, count=1. Next cycle, read -> rd_data=0x55, rd_valid=1.
- Full FIFO, wr_en=1 (0x77) and rd_en=1 together -> no overflow, count stays 32, oldest word returned. After 31 further reads, 0x77 emerges last.
- DEPTH=5: 12 write/read pairs with 2-deep occupancy -> pointers wrap 4->0, data order preserved, count never exceeds 2.
- Assert rst mid-stream with count=10, asynchronously between edges -> outputs reset immediately without a clock edge. After release, empty=1; a subsequent read gives underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the register-file backed FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Explicit wrap so non power-of-two depths work
  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ram_dp_sync.sv
// Dual-port register-file RAM, registered read, read-before-write.
module ram_dp_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO: pointers, occupancy, flags and error pulses
// around a dual-port register-file RAM.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4,
  localparam int AW      = clog2(DEPTH),
  localparam int CW      = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_rd_valid;
  logic             r_rd_seen;
  logic             r_ovf;
  logic             r_unf;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  ram_dp_sync #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_wr_acc),
    .waddr(r_wr_ptr),
    .wdata(wr_data),
    .re   (w_rd_acc),
    .raddr(r_rd_ptr),
    .rdata(w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= AW'(ptr_inc(int'(r_wr_ptr), DEPTH));
      if (w_rd_acc) begin
        r_rd_ptr  <= AW'(ptr_inc(int'(r_rd_ptr), DEPTH));
        r_rd_seen <= 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_rd_valid <= w_rd_acc;
      r_ovf      <= wr_en & ~w_wr_acc;
      r_unf      <= rd_en & ~w_rd_acc;
    end
  end

  // RAM read register has no reset; mask it until the first pop
  assign rd_data      = r_rd_seen ? w_ram_rdata : '0;
  assign rd_valid     = r_rd_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed and random checks of sync_fifo_ram against a queue model.
module tb_sync_fifo_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [5:0] count;
  logic       overflow, underflow;

  logic       rst5;
  logic       wr_en5, rd_en5;
  logic [7:0] wr_data5, rd_data5;
  logic       rd_valid5, full5, empty5, af5, ae5;
  logic [2:0] count5;
  logic       ovf5, unf5;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_data;
  bit         m_valid, m_ovf, m_unf;
  logic [7:0] q5[$];
  logic [7:0] m5_data;
  bit         m5_valid;

  always #5 clk = ~clk;

  sync_fifo_ram dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_ram #(
    .WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut5 (
    .clk(clk), .rst(rst5),
    .wr_en(wr_en5), .wr_data(wr_data5), .rd_en(rd_en5),
    .rd_data(rd_data5), .rd_valid(rd_valid5),
    .full(full5), .empty(empty5),
    .almost_full(af5), .almost_empty(ae5),
    .count(count5), .overflow(ovf5), .underflow(unf5)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 32));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 28));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 4));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_data));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd);
    bit ra, wa;
    wr_en = wr; wr_data = d; rd_en = rd;
    @(posedge clk);
    ra = rd && (q.size() != 0);
    wa = wr && ((q.size() < 32) || ra);
    m_valid = ra;
    if (ra) m_data = q.pop_front();
    if (wa) q.push_back(d);
    m_ovf = wr && !wa;
    m_unf = rd && !ra;
    #1 check_all();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic cyc5(input bit wr, input logic [7:0] d, input bit rd);
    bit ra, wa;
    wr_en5 = wr; wr_data5 = d; rd_en5 = rd;
    @(posedge clk);
    ra = rd && (q5.size() != 0);
    wa = wr && ((q5.size() < 5) || ra);
    m5_valid = ra;
    if (ra) m5_data = q5.pop_front();
    if (wa) q5.push_back(d);
    #1;
    chk("d5_count", 32'(count5), 32'(q5.size()));
    chk("d5_le2", 32'(count5 <= 3'd2), 32'd1);
    chk("d5_rd_valid", 32'(rd_valid5), 32'(m5_valid));
    chk("d5_rd_data", 32'(rd_data5), 32'(m5_data));
    wr_en5 = 1'b0; rd_en5 = 1'b0;
  endtask

  initial begin
    int pw, pr;
    rst = 1'b1; rst5 = 1'b1;
    wr_en = 0; rd_en = 0; wr_data = 0;
    wr_en5 = 0; rd_en5 = 0; wr_data5 = 0;
    m_data = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    m5_data = 0; m5_valid = 0;
    #7;
    check_all();
    @(negedge clk);
    rst = 1'b0; rst5 = 1'b0;

    // idle after reset
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0);

    // fill, overflow, drain in order
    for (int i = 0; i < 32; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hAA, 0);
    for (int i = 0; i < 32; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // empty: simultaneous read+write, no fall-through
    cyc(1, 8'h55, 1);
    cyc(0, 8'h00, 1);
    chk("fallthru_data", 32'(rd_data), 32'h55);

    // full: simultaneous write+read accepted
    for (int i = 0; i < 32; i++) cyc(1, 8'($urandom), 0);
    cyc(1, 8'h77, 1);
    for (int i = 0; i < 32; i++) cyc(0, 8'h00, 1);
    chk("last_77", 32'(rd_data), 32'h77);

    // small non power-of-two depth, wrapping pointers
    cyc5(1, 8'hC0, 0);
    cyc5(1, 8'hC1, 0);
    for (int i = 0; i < 12; i++) cyc5(1, 8'(8'hD0 + i), 1);
    cyc5(0, 8'h00, 1);
    cyc5(0, 8'h00, 1);
    cyc5(0, 8'h00, 1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 0);
    chk("pre_rst_count", 32'(count), 32'd10);
    #3 rst = 1'b1;
    q.delete();
    m_data = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    #1 check_all();
    #2 rst = 1'b0;
    cyc(0, 8'h00, 1);

    // random traffic with shifting bias
    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph % 2 == 0) ? 75 : 30;
      pr = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 120; i++)
        cyc($urandom_range(0, 99) < pw, 8'($urandom),
            $urandom_range(0, 99) < pr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
